drain_collector: RTL and testbench

- Consumes the serial result stream from the systolic array's drain channel: one `drain_data_t` per cycle, `{data, enable}`.
- Buffers results in a small FIFO.
- Writes each C element to memory at consecutive addresses starting from the `c_addr` supplied with the drain command.
- Sits directly downstream of the PE array and upstream of the memory write port; signals completion to the controller.

---
 rtl/drain_collector.sv | 152 +++++++++++++++
 tb/tb_drain_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/drain_collector.sv
// rtl/drain_collector.sv - systolic drain collector: buffers drained results and writes them to consecutive addresses
module drain_collector #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYS_ARRAY_SIZE = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_en,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH:0]   drain_in,
    output logic                  drain_ready,
    output logic                  mem_wr_valid,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int NUM_ELEMS = SYS_ARRAY_SIZE * SYS_ARRAY_SIZE;
    localparam int CNT_W     = $clog2(NUM_ELEMS + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int BYTES     = DATA_WIDTH / 8;

    localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_ELEMS);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          count_q, count_d;

    logic                    in_enable;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    push;
    logic                    pop;

    // drain_data_t packs {data, enable}: enable sits in the LSB
    assign in_enable = drain_in[0];
    assign in_data   = drain_in[DATA_WIDTH:1];

    assign drain_ready  = (state_q == ST_DRAIN) && (count_q < DEPTH_C);
    assign mem_wr_valid = (count_q != '0);
    assign mem_wr_data  = fifo_q[rd_ptr_q];
    assign mem_wr_addr  = base_q + ADDR_WIDTH'(wr_cnt_q) * ADDR_WIDTH'(BYTES);
    assign busy         = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
    assign done         = (state_q == ST_DONE);
    assign overflow     = overflow_q;

    assign push = in_enable && drain_ready;
    assign pop  = mem_wr_valid && mem_wr_ready;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rx_cnt_d   = rx_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            rx_cnt_d         = rx_cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (drain_en) begin
                    base_d     = c_addr;
                    rx_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_enable && !drain_ready) begin
                    overflow_d = 1'b1;
                end
                if (push && (rx_cnt_d == NUM_C)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // look at post-pop values so done lands the cycle after the last write
                if ((count_d == '0) && (wr_cnt_d == NUM_C)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            rx_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rx_cnt_q   <= rx_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_drain_collector.sv
// tb/tb_drain_collector.sv - randomized and directed checks of drain_collector against a queue-based model
module tb_drain_collector;
    localparam int DW    = 8;
    localparam int AW    = 64;
    localparam int DEPTH = 4;
    localparam int NA    = 2;
    localparam int NB    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_drain_en, a_drain_ready, a_valid, a_wr_ready, a_busy, a_done, a_ovf;
    logic [AW-1:0] a_c_addr, a_addr;
    logic [DW:0]   a_drain_in;
    logic [DW-1:0] a_data;

    logic          b_drain_en, b_drain_ready, b_valid, b_wr_ready, b_busy, b_done, b_ovf;
    logic [AW-1:0] b_c_addr, b_addr;
    logic [DW:0]   b_drain_in;
    logic [DW-1:0] b_data;

    drain_collector #(.DATA_WIDTH(DW), .SYS_ARRAY_SIZE(NA), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .rst(rst), .drain_en(a_drain_en), .c_addr(a_c_addr), .drain_in(a_drain_in),
        .drain_ready(a_drain_ready), .mem_wr_valid(a_valid), .mem_wr_addr(a_addr), .mem_wr_data(a_data),
        .mem_wr_ready(a_wr_ready), .busy(a_busy), .done(a_done), .overflow(a_ovf)
    );

    drain_collector #(.DATA_WIDTH(DW), .SYS_ARRAY_SIZE(NB), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .rst(rst), .drain_en(b_drain_en), .c_addr(b_c_addr), .drain_in(b_drain_in),
        .drain_ready(b_drain_ready), .mem_wr_valid(b_valid), .mem_wr_addr(b_addr), .mem_wr_data(b_data),
        .mem_wr_ready(b_wr_ready), .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef enum {M_IDLE, M_DRAIN, M_FLUSH, M_DONE} mode_t;
    mode_t        m_mode;
    logic [63:0]  m_base;
    int           m_rx, m_wr;
    bit           m_ovf;
    logic [7:0]   m_q[$];
    int           cyc, done_cyc, done_cnt;

    function automatic bit m_ready();
        return (m_mode == M_DRAIN) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_base = '0;
        m_rx   = 0;
        m_wr   = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_a();
        chk("drain_ready", 64'(a_drain_ready), 64'(m_ready()));
        chk("wr_valid", 64'(a_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("wr_addr", a_addr, m_base + 64'(m_wr));
            chk("wr_data", 64'(a_data), 64'(m_q[0]));
        end
        chk("busy", 64'(a_busy), 64'(m_mode == M_DRAIN || m_mode == M_FLUSH));
        chk("done", 64'(a_done), 64'(m_mode == M_DONE));
        chk("overflow", 64'(a_ovf), 64'(m_ovf));
    endtask

    // One clock of DUT A: check outputs, drive inputs, advance the model, move to the next negedge
    task automatic step_a(input bit st, input logic [63:0] addr, input bit en, input logic [7:0] d, input bit wr);
        mode_t old;
        bit rdy, pop, push;
        check_a();
        if (a_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        a_drain_en = st;
        a_c_addr   = addr;
        a_drain_in = {d, en};
        a_wr_ready = wr;
        old  = m_mode;
        rdy  = m_ready();
        pop  = (m_q.size() > 0) && wr;
        push = en && rdy;
        if (pop) begin
            void'(m_q.pop_front());
            m_wr++;
        end
        if (push) begin
            m_q.push_back(d);
            m_rx++;
        end
        case (old)
            M_IDLE: if (st) begin
                m_base = addr; m_rx = 0; m_wr = 0; m_ovf = 1'b0; m_mode = M_DRAIN;
            end
            M_DRAIN: begin
                if (en && !rdy) m_ovf = 1'b1;
                if (push && m_rx == NA * NA) m_mode = M_FLUSH;
            end
            M_FLUSH: if (m_q.size() == 0 && m_wr == NA * NA) m_mode = M_DONE;
            M_DONE:  m_mode = M_IDLE;
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_stream(input logic [63:0] base, input int wr_hold);
        logic [7:0] vals [4];
        int start_cyc;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        done_cyc  = -1;
        done_cnt  = 0;
        start_cyc = cyc;
        step_a(1'b1, base, 1'b0, 8'h00, wr_hold == 0);
        for (int i = 0; i < 4; i++) step_a(1'b0, '0, 1'b1, vals[i], (i + 1) >= wr_hold);
        for (int i = 0; i < 10; i++) step_a(1'b0, '0, 1'b0, 8'h00, (i + 5) >= wr_hold);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        if (wr_hold == 0) chk("done_latency", 64'(done_cyc - start_cyc), 64'd6);
    endtask

    logic [7:0] exp_b[$];

    initial begin
        rst = 1'b1;
        a_drain_en = 0; a_c_addr = '0; a_drain_in = '0; a_wr_ready = 0;
        b_drain_en = 0; b_c_addr = '0; b_drain_in = '0; b_wr_ready = 0;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_addr", a_addr, 64'd0);
        chk("rst_data", 64'(a_data), 64'd0);
        check_a();
        rst = 1'b0;

        // Basic stream, then back-pressured stream, then wrap
        run_stream(64'h1000, 0);
        run_stream(64'h1000, 7);
        chk("bp_no_ovf", 64'(a_ovf), 64'd0);
        run_stream(64'hFFFF_FFFF_FFFF_FFFE, 0);

        // Start while busy is ignored
        step_a(1'b1, 64'h1000, 1'b0, 8'h00, 1'b1);
        step_a(1'b0, '0, 1'b1, 8'h11, 1'b1);
        step_a(1'b1, 64'h2000, 1'b1, 8'h22, 1'b1);
        step_a(1'b1, 64'h2000, 1'b1, 8'h33, 1'b1);
        step_a(1'b0, '0, 1'b1, 8'h44, 1'b1);
        repeat (5) step_a(1'b0, '0, 1'b0, 8'h00, 1'b1);

        // Async reset with two elements buffered
        step_a(1'b1, 64'h1000, 1'b0, 8'h00, 1'b0);
        step_a(1'b0, '0, 1'b1, 8'hA1, 1'b0);
        step_a(1'b0, '0, 1'b1, 8'hA2, 1'b0);
        chk("pre_rst_valid", 64'(a_valid), 64'd1);
        a_drain_in = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(a_valid), 64'd0);
        chk("rst_async_busy", 64'(a_busy), 64'd0);
        chk("rst_async_done", 64'(a_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_stream(64'h3000, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                             : {$urandom, $urandom};
            step_a($urandom_range(0, 7) == 0, ra, $urandom_range(0, 3) != 0,
                   8'($urandom), $urandom_range(0, 2) != 0);
        end
        repeat (2) step_a(1'b0, '0, 1'b0, 8'h00, 1'b0);

        // N=4 overflow scenario on the second instance
        b_drain_en = 1'b1; b_c_addr = 64'h4000; b_wr_ready = 1'b0;
        @(negedge clk);
        b_drain_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("b_ready", 64'(b_drain_ready), 64'(k <= 4));
            chk("b_ovf_seq", 64'(b_ovf), 64'(k >= 6));
            b_drain_in = {8'(k), 1'b1};
            @(negedge clk);
        end
        b_drain_in = '0;
        chk("b_ovf_set", 64'(b_ovf), 64'd1);
        chk("b_ready_full", 64'(b_drain_ready), 64'd0);
        chk("b_hold_addr", b_addr, 64'h4000);
        chk("b_hold_data", 64'(b_data), 64'd1);
        for (int k = 1; k <= 4; k++) exp_b.push_back(8'(k));
        for (int k = 7; k <= 18; k++) exp_b.push_back(8'(k));
        begin
            int nw, nxt, ndone;
            nw = 0; nxt = 7; ndone = 0;
            b_wr_ready = 1'b1;
            for (int c = 0; c < 80; c++) begin
                if (b_done) ndone++;
                if (b_valid) begin
                    chk("b_wr_addr", b_addr, 64'h4000 + 64'(nw));
                    chk("b_wr_data", 64'(b_data), (nw < 16) ? 64'(exp_b[nw]) : 64'hFFFF);
                    nw++;
                end
                if (b_drain_ready && nxt <= 18) begin
                    b_drain_in = {8'(nxt), 1'b1};
                    nxt++;
                end else begin
                    b_drain_in = '0;
                end
                @(negedge clk);
            end
            chk("b_write_count", 64'(nw), 64'd16);
            chk("b_done_count", 64'(ndone), 64'd1);
        end
        b_drain_en = 1'b1; b_c_addr = 64'h5000;
        @(negedge clk);
        b_drain_en = 1'b0;
        chk("b_ovf_cleared", 64'(b_ovf), 64'd0);
        chk("b_busy_restart", 64'(b_busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
